// File: rtl/mem_stage_if.sv
// Bundles the EX->MEM handshake, the data-memory port and the MEM->WB handshake.
// The stage connects through 'slave'; the surrounding pipeline/memory uses 'master'.
interface mem_stage_if #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
);
  logic                 ms_ready;
  logic                 ms_valid;
  logic [XLEN-1:0]      ms_bits_pc;
  logic                 ms_bits_rf_we;
  logic [RF_ADDR_W-1:0] ms_bits_rf_waddr;
  logic [XLEN-1:0]      ms_bits_alu_result;
  logic                 ms_bits_mem_re;
  logic                 ms_bits_mem_we;
  logic [XLEN-1:0]      ms_bits_mem_wdata;
  logic [2:0]           ms_bits_mem_op;

  logic                 dmem_req_valid;
  logic                 dmem_req_ready;
  logic                 dmem_req_we;
  logic [XLEN-1:0]      dmem_req_addr;
  logic [XLEN-1:0]      dmem_req_wdata;
  logic [3:0]           dmem_req_wstrb;
  logic                 dmem_resp_valid;
  logic [XLEN-1:0]      dmem_resp_rdata;

  logic                 ws_valid;
  logic                 ws_ready;
  logic [XLEN-1:0]      ws_bits_pc;
  logic                 ws_bits_rf_we;
  logic [RF_ADDR_W-1:0] ws_bits_rf_waddr;
  logic [XLEN-1:0]      ws_bits_rf_wdata;

  modport slave (
    output ms_ready,
    input  ms_valid, ms_bits_pc, ms_bits_rf_we, ms_bits_rf_waddr, ms_bits_alu_result,
    input  ms_bits_mem_re, ms_bits_mem_we, ms_bits_mem_wdata, ms_bits_mem_op,
    output dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    input  dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    output ws_valid, ws_bits_pc, ws_bits_rf_we, ws_bits_rf_waddr, ws_bits_rf_wdata,
    input  ws_ready
  );

  modport master (
    input  ms_ready,
    output ms_valid, ms_bits_pc, ms_bits_rf_we, ms_bits_rf_waddr, ms_bits_alu_result,
    output ms_bits_mem_re, ms_bits_mem_we, ms_bits_mem_wdata, ms_bits_mem_op,
    input  dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_wstrb,
    output dmem_req_ready, dmem_resp_valid, dmem_resp_rdata,
    input  ws_valid, ws_bits_pc, ws_bits_rf_we, ws_bits_rf_waddr, ws_bits_rf_wdata,
    output ws_ready
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores to the data port, formats load
// data and hands the write-back bundle to WB. ALU results pass through in one cycle.
module mem_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  mem_stage_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]           r_state;
  logic [XLEN-1:0]      r_pc;
  logic                 r_rf_we;
  logic [RF_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]      r_alu;
  logic                 r_mem_re;
  logic                 r_mem_we;
  logic [XLEN-1:0]      r_wdata;
  logic [2:0]           r_mem_op;
  logic [XLEN-1:0]      r_rf_wdata;

  logic                 w_accept;
  logic                 w_is_mem;
  logic                 w_is_store;
  logic                 w_byte;
  logic                 w_half;
  logic [7:0]           w_ld_byte;
  logic [15:0]          w_ld_half;
  logic [XLEN-1:0]      w_ld_data;
  logic [XLEN-1:0]      w_st_data;
  logic [3:0]           w_st_strb;

  assign bus.ms_ready = (r_state == IDLE) | ((r_state == HOLD) & bus.ws_ready);
  assign w_accept     = bus.ms_valid & bus.ms_ready;
  assign w_is_mem     = bus.ms_bits_mem_re | bus.ms_bits_mem_we;
  assign w_is_store   = r_mem_we & ~r_mem_re;

  // funct3[1:0] picks the access size; funct3[2] selects zero extension.
  assign w_byte = (r_mem_op[1:0] == 2'b00);
  assign w_half = (r_mem_op[1:0] == 2'b01);

  always_comb begin
    w_ld_byte = bus.dmem_resp_rdata[7:0];
    case (r_alu[1:0])
      2'd1:    w_ld_byte = bus.dmem_resp_rdata[15:8];
      2'd2:    w_ld_byte = bus.dmem_resp_rdata[23:16];
      2'd3:    w_ld_byte = bus.dmem_resp_rdata[31:24];
      default: w_ld_byte = bus.dmem_resp_rdata[7:0];
    endcase
    w_ld_half = r_alu[1] ? bus.dmem_resp_rdata[31:16] : bus.dmem_resp_rdata[15:0];
    if (w_byte)
      w_ld_data = {{(XLEN-8){~r_mem_op[2] & w_ld_byte[7]}}, w_ld_byte};
    else if (w_half)
      w_ld_data = {{(XLEN-16){~r_mem_op[2] & w_ld_half[15]}}, w_ld_half};
    else
      w_ld_data = bus.dmem_resp_rdata;
  end

  always_comb begin
    w_st_strb = 4'b1111;
    w_st_data = r_wdata;
    if (w_byte) begin
      w_st_strb = 4'b0001 << r_alu[1:0];
      w_st_data = {4{r_wdata[7:0]}};
    end else if (w_half) begin
      w_st_strb = r_alu[1] ? 4'b1100 : 4'b0011;
      w_st_data = {2{r_wdata[15:0]}};
    end
  end

  assign bus.dmem_req_valid = (r_state == REQ);
  assign bus.dmem_req_we    = w_is_store;
  assign bus.dmem_req_addr  = {r_alu[XLEN-1:2], 2'b00};
  assign bus.dmem_req_wdata = w_st_data;
  assign bus.dmem_req_wstrb = w_is_store ? w_st_strb : 4'b0000;

  assign bus.ws_valid         = (r_state == HOLD);
  assign bus.ws_bits_pc       = r_pc;
  assign bus.ws_bits_rf_we    = r_rf_we;
  assign bus.ws_bits_rf_waddr = r_rf_waddr;
  assign bus.ws_bits_rf_wdata = r_rf_wdata;

  // Responses are only honoured in WAIT, so a late response after reset is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_pc       <= '0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_alu      <= '0;
      r_mem_re   <= 1'b0;
      r_mem_we   <= 1'b0;
      r_wdata    <= '0;
      r_mem_op   <= '0;
      r_rf_wdata <= '0;
    end else begin
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            r_pc       <= bus.ms_bits_pc;
            r_rf_we    <= bus.ms_bits_rf_we;
            r_rf_waddr <= bus.ms_bits_rf_waddr;
            r_alu      <= bus.ms_bits_alu_result;
            r_mem_re   <= bus.ms_bits_mem_re;
            r_mem_we   <= bus.ms_bits_mem_we;
            r_wdata    <= bus.ms_bits_mem_wdata;
            r_mem_op   <= bus.ms_bits_mem_op;
            r_rf_wdata <= bus.ms_bits_alu_result;
            r_state    <= w_is_mem ? REQ : HOLD;
          end else if ((r_state == HOLD) && bus.ws_ready) begin
            r_state <= IDLE;
          end
        end
        REQ: begin
          if (bus.dmem_req_ready)
            r_state <= WAIT;
        end
        WAIT: begin
          if (bus.dmem_resp_valid) begin
            r_state <= HOLD;
            if (r_mem_re)
              r_rf_wdata <= w_ld_data;
            else
              r_rf_we <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected WB bundles and memory requests are queued
// when a bundle is driven and compared when the stage produces them.
module tb_mem_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mem_stage_if #(.XLEN(32), .RF_ADDR_W(5)) bus ();

  mem_stage #(.XLEN(32), .RF_ADDR_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wsExp_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } reqExp_t;

  wsExp_t  wsQ[$];
  reqExp_t reqQ[$];
  wsExp_t  wsE;
  reqExp_t reqE;
  int compareCount = 0;
  int failCount    = 0;
  int wsCount      = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Scoreboard monitor: sampled on the falling edge, i.e. what the next rising edge will see.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && bus.ws_valid && bus.ws_ready) begin
        wsCount++;
        checkOutput("ws_pending", 32'(wsQ.size() != 0), 32'd1);
        if (wsQ.size() != 0) begin
          wsE = wsQ.pop_front();
          checkOutput("ws_pc",    bus.ws_bits_pc, wsE.pc);
          checkOutput("ws_we",    32'(bus.ws_bits_rf_we), 32'(wsE.we));
          checkOutput("ws_waddr", 32'(bus.ws_bits_rf_waddr), 32'(wsE.waddr));
          checkOutput("ws_wdata", bus.ws_bits_rf_wdata, wsE.wdata);
        end
      end
      if (reset && bus.dmem_req_valid && bus.dmem_req_ready) begin
        checkOutput("req_pending", 32'(reqQ.size() != 0), 32'd1);
        if (reqQ.size() != 0) begin
          reqE = reqQ.pop_front();
          checkOutput("req_we",   32'(bus.dmem_req_we), 32'(reqE.we));
          checkOutput("req_addr", bus.dmem_req_addr, reqE.addr);
          checkOutput("req_strb", 32'(bus.dmem_req_wstrb), 32'(reqE.strb));
          if (reqE.we)
            checkOutput("req_wdata", bus.dmem_req_wdata, reqE.wdata);
        end
      end
    end
  end

  // Drives one EX bundle (entered and left at posedge+1) and, for memory ops, plays the memory.
  task automatic applyStimulus(
    input logic [31:0] pc, input logic rfWe, input logic [4:0] waddr, input logic [31:0] alu,
    input logic re, input logic mwe, input logic [31:0] wdata, input logic [2:0] op,
    input logic [31:0] rdata, input int reqStall, input int respDelay, input int wsStall,
    input logic expRfWe, input logic [31:0] expRfWdata,
    input logic [31:0] expAddr, input logic [31:0] expReqWdata, input logic [3:0] expStrb,
    output int waits);
    logic accepted;
    waits = 0;
    accepted = 1'b0;
    wsQ.push_back('{pc: pc, we: expRfWe, waddr: waddr, wdata: expRfWdata});
    if (re || mwe)
      reqQ.push_back('{we: mwe, addr: expAddr, wdata: expReqWdata, strb: expStrb});
    bus.ms_bits_pc         = pc;
    bus.ms_bits_rf_we      = rfWe;
    bus.ms_bits_rf_waddr   = waddr;
    bus.ms_bits_alu_result = alu;
    bus.ms_bits_mem_re     = re;
    bus.ms_bits_mem_we     = mwe;
    bus.ms_bits_mem_wdata  = wdata;
    bus.ms_bits_mem_op     = op;
    bus.ms_valid           = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clock);
      if (bus.ms_ready) begin
        @(posedge clock); #1;
        accepted = 1'b1;
      end else begin
        waits++;
      end
    end
    bus.ms_valid = 1'b0;
    checkOutput("accept_in_time", 32'(accepted), 32'd1);
    if (accepted && (re || mwe)) begin
      bus.dmem_req_ready = 1'b0;
      for (int i = 0; i < reqStall; i++) begin
        @(negedge clock);
        checkOutput("req_hold_valid",   32'(bus.dmem_req_valid), 32'd1);
        checkOutput("req_hold_addr",    bus.dmem_req_addr, expAddr);
        checkOutput("req_hold_strb",    32'(bus.dmem_req_wstrb), 32'(expStrb));
        checkOutput("req_hold_msready", 32'(bus.ms_ready), 32'd0);
        @(posedge clock); #1;
      end
      bus.dmem_req_ready = 1'b1;
      @(posedge clock); #1;
      bus.dmem_req_ready = 1'b0;
      for (int i = 0; i < respDelay; i++) begin
        @(negedge clock);
        checkOutput("wait_msready",  32'(bus.ms_ready), 32'd0);
        checkOutput("wait_ws_valid", 32'(bus.ws_valid), 32'd0);
        @(posedge clock); #1;
      end
      if (wsStall > 0) bus.ws_ready = 1'b0;
      bus.dmem_resp_valid = 1'b1;
      bus.dmem_resp_rdata = rdata;
      @(posedge clock); #1;
      bus.dmem_resp_valid = 1'b0;
      bus.dmem_resp_rdata = 32'h0;
      for (int i = 0; i < wsStall; i++) begin
        @(negedge clock);
        checkOutput("hold_ws_valid", 32'(bus.ws_valid), 32'd1);
        checkOutput("hold_msready",  32'(bus.ms_ready), 32'd0);
        @(posedge clock); #1;
      end
      bus.ws_ready = 1'b1;
    end
  endtask

  task automatic drainOutputs();
    for (int i = 0; i < 20 && wsQ.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    checkOutput("ws_drained", 32'(wsQ.size()), 32'd0);
  endtask

  int w;
  int wsBefore;

  initial begin
    bus.ms_valid = 1'b0;
    bus.ms_bits_pc = '0; bus.ms_bits_rf_we = 1'b0; bus.ms_bits_rf_waddr = '0;
    bus.ms_bits_alu_result = '0; bus.ms_bits_mem_re = 1'b0; bus.ms_bits_mem_we = 1'b0;
    bus.ms_bits_mem_wdata = '0; bus.ms_bits_mem_op = '0;
    bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0; bus.dmem_resp_rdata = '0;
    bus.ws_ready = 1'b1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_ws_valid",  32'(bus.ws_valid), 32'd0);
    checkOutput("rst_req_valid", 32'(bus.dmem_req_valid), 32'd0);
    checkOutput("rst_ms_ready",  32'(bus.ms_ready), 32'd1);
    checkOutput("rst_ws_pc",     bus.ws_bits_pc, 32'd0);
    checkOutput("rst_ws_wdata",  bus.ws_bits_rf_wdata, 32'd0);
    checkOutput("rst_req_addr",  bus.dmem_req_addr, 32'd0);
    checkOutput("rst_req_strb",  32'(bus.dmem_req_wstrb), 32'd0);
    reset = 1'b1;
    @(posedge clock); #1;

    $display("[TB] ALU pass-through and back-to-back");
    applyStimulus(32'h80000000, 1, 5'd5, 32'h00001234, 0, 0, 0, 3'b000, 0, 0, 0, 0,
                  1, 32'h00001234, 0, 0, 0, w);
    @(negedge clock);
    checkOutput("alu_latency", 32'(bus.ws_valid), 32'd1);
    @(posedge clock); #1;
    wsBefore = wsCount;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h80000004 + 32'(4*k), 1, 5'(k + 1), 32'h00000100 + 32'(k), 0, 0, 0, 3'b000,
                    0, 0, 0, 0, 1, 32'h00000100 + 32'(k), 0, 0, 0, w);
      if (k > 0) checkOutput("b2b_no_wait", 32'(w), 32'd0);
    end
    drainOutputs();
    checkOutput("b2b_count", 32'(wsCount - wsBefore), 32'd4);

    $display("[TB] loads");
    applyStimulus(32'h80000010, 1, 5'd6, 32'h80000103, 1, 0, 0, 3'b000, 32'h80FF0000, 0, 0, 0,
                  1, 32'hFFFFFF80, 32'h80000100, 0, 4'b0000, w);
    applyStimulus(32'h80000014, 1, 5'd7, 32'h80000103, 1, 0, 0, 3'b100, 32'h80FF0000, 1, 1, 0,
                  1, 32'h00000080, 32'h80000100, 0, 4'b0000, w);
    applyStimulus(32'h80000018, 1, 5'd8, 32'h80000102, 1, 0, 0, 3'b001, 32'h9ABC1234, 0, 0, 0,
                  1, 32'hFFFF9ABC, 32'h80000100, 0, 4'b0000, w);
    applyStimulus(32'h8000001C, 1, 5'd9, 32'h80000102, 1, 0, 0, 3'b101, 32'h9ABC1234, 0, 0, 0,
                  1, 32'h00009ABC, 32'h80000100, 0, 4'b0000, w);
    applyStimulus(32'h80000020, 1, 5'd10, 32'h80000100, 1, 0, 0, 3'b001, 32'h9ABC1234, 0, 0, 0,
                  1, 32'h00001234, 32'h80000100, 0, 4'b0000, w);
    applyStimulus(32'h80000024, 1, 5'd11, 32'h80000101, 1, 0, 0, 3'b001, 32'h9ABC8001, 0, 0, 0,
                  1, 32'hFFFF8001, 32'h80000100, 0, 4'b0000, w);
    applyStimulus(32'h80000028, 1, 5'd12, 32'h80000100, 1, 0, 0, 3'b000, 32'h1234567F, 0, 0, 0,
                  1, 32'h0000007F, 32'h80000100, 0, 4'b0000, w);
    applyStimulus(32'h8000002C, 1, 5'd13, 32'h80000307, 1, 0, 0, 3'b010, 32'hCAFEF00D, 0, 0, 0,
                  1, 32'hCAFEF00D, 32'h80000304, 0, 4'b0000, w);
    drainOutputs();

    $display("[TB] stores");
    applyStimulus(32'h80000030, 1, 5'd14, 32'h80000201, 0, 1, 32'h000000AB, 3'b000, 0, 0, 0, 0,
                  0, 32'h80000201, 32'h80000200, 32'hABABABAB, 4'b0010, w);
    applyStimulus(32'h80000034, 1, 5'd15, 32'h80000202, 0, 1, 32'h0000CDEF, 3'b001, 0, 0, 0, 0,
                  0, 32'h80000202, 32'h80000200, 32'hCDEFCDEF, 4'b1100, w);
    applyStimulus(32'h80000038, 1, 5'd16, 32'h80000204, 0, 1, 32'h11223344, 3'b010, 0, 0, 0, 0,
                  0, 32'h80000204, 32'h80000204, 32'h11223344, 4'b1111, w);
    drainOutputs();

    $display("[TB] backpressure");
    wsBefore = wsCount;
    applyStimulus(32'h80000040, 1, 5'd17, 32'h80000308, 1, 0, 0, 3'b010, 32'h0BADBEEF, 3, 2, 2,
                  1, 32'h0BADBEEF, 32'h80000308, 0, 4'b0000, w);
    drainOutputs();
    checkOutput("bp_single_ws", 32'(wsCount - wsBefore), 32'd1);

    $display("[TB] reset during WAIT");
    reqQ.push_back('{we: 1'b0, addr: 32'h80000400, wdata: 32'h0, strb: 4'b0000});
    bus.ms_bits_pc = 32'h80000050; bus.ms_bits_rf_we = 1'b1; bus.ms_bits_rf_waddr = 5'd18;
    bus.ms_bits_alu_result = 32'h80000400; bus.ms_bits_mem_re = 1'b1; bus.ms_bits_mem_we = 1'b0;
    bus.ms_bits_mem_op = 3'b010; bus.ms_valid = 1'b1;
    @(negedge clock);
    checkOutput("rmo_accept_ready", 32'(bus.ms_ready), 32'd1);
    @(posedge clock); #1;
    bus.ms_valid = 1'b0;
    bus.dmem_req_ready = 1'b1;
    @(posedge clock); #1;
    bus.dmem_req_ready = 1'b0;
    @(negedge clock);
    checkOutput("rmo_wait_msready", 32'(bus.ms_ready), 32'd0);
    reset = 1'b0;
    #2;
    checkOutput("rmo_rst_ws_valid",  32'(bus.ws_valid), 32'd0);
    checkOutput("rmo_rst_req_valid", 32'(bus.dmem_req_valid), 32'd0);
    checkOutput("rmo_rst_msready",   32'(bus.ms_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_resp_rdata = 32'hDEADBEEF;
    @(posedge clock); #1;
    bus.dmem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkOutput("rmo_ws_stays_low", 32'(bus.ws_valid), 32'd0);
      checkOutput("rmo_idle_msready", 32'(bus.ms_ready), 32'd1);
    end
    checkOutput("req_queue_empty", 32'(reqQ.size()), 32'd0);
    checkOutput("ws_queue_empty",  32'(wsQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage NPC pipeline; sits between EX and WB_stage.
- Accepts one EX result at a time and, for loads and stores, issues a request to the data-memory port and waits for its response.
- Formats load data (sign or zero extension, byte/half lane select) and presents the write-back bundle to WB with a valid/ready handshake.
- Non-memory instructions pass through with a single register of latency.

Parameters:
- XLEN, 32, datapath and address width.
- RF_ADDR_W, 5, register-file address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ms_ready  out  1  stage can accept an EX bundle this cycle.
- ms_valid  in  1  EX bundle valid.
- ms_bits_pc  in  XLEN  instruction PC.
- ms_bits_rf_we  in  1  register write enable.
- ms_bits_rf_waddr  in  RF_ADDR_W  destination register.
- ms_bits_alu_result  in  XLEN  ALU result, which is the effective address for memory ops.
- ms_bits_mem_re  in  1  load.
- ms_bits_mem_we  in  1  store.
- ms_bits_mem_wdata  in  XLEN  store data, rs2.
- ms_bits_mem_op  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- dmem_req_valid  out  1  memory request valid.
- dmem_req_ready  in  1  memory accepts request.
- dmem_req_we  out  1  1 = write.
- dmem_req_addr  out  XLEN  word-aligned address.
- dmem_req_wdata  out  XLEN  lane-replicated store data.
- dmem_req_wstrb  out  4  byte strobes.
- dmem_resp_valid  in  1  response (read data or write ack).
- dmem_resp_rdata  in  XLEN  read word.
- ws_valid  out  1  bundle to WB valid.
- ws_ready  in  1  WB accepts.
- ws_bits_pc  out  XLEN  PC.
- ws_bits_rf_we  out  1  register write enable.
- ws_bits_rf_waddr  out  RF_ADDR_W  destination register.
- ws_bits_rf_wdata  out  XLEN  write-back data.

Behaviour:

Reset:
- reset low asynchronously forces state IDLE and clears all captured registers.
- Reset values: ws_valid=0, dmem_req_valid=0, ws_bits_*=0, dmem_req_* =0.
- An outstanding memory transaction is abandoned on reset. A dmem_resp_valid arriving in IDLE is ignored.

States: IDLE, REQ, WAIT, HOLD.
- ms_ready = (state==IDLE) | (state==HOLD & ws_ready).
- Accept event = ms_valid & ms_ready. On accept, capture all ms_bits_*.
  - If mem_re|mem_we, go to REQ.
  - Otherwise go to HOLD with rf_wdata = alu_result.
- REQ: dmem_req_valid=1, driven from the captured bundle.
  - dmem_req_ready=1 moves to WAIT. Request fields are held stable until then.
  - req_ready and resp_valid in the same cycle is not allowed: the response is counted only in WAIT.
- WAIT: on dmem_resp_valid, go to HOLD.
  - For a load, rf_wdata = formatted rdata.
  - For a store, rf_wdata = alu_result and rf_we is forced to 0.
- HOLD: ws_valid=1 and ws_bits stable.
  - ws_ready=1 with no new accept moves to IDLE.
  - ws_ready=1 with a simultaneous accept goes directly to REQ or HOLD for the new bundle (back-to-back ALU ops reach 1/cycle).
- ms_valid when ms_ready=0 is not captured; EX holds its bundle.

Latency:
- ALU op: ws_valid in the cycle after accept.
- Memory op: 1 + request-wait + response-wait cycles, minimum 3 cycles from accept to ws_valid.

Address and lanes (a = alu_result):
- dmem_req_addr = {a[31:2],2'b00}.
- Byte: lane = a[1:0], wstrb = 4'b0001<<a[1:0], wdata = {4{wdata[7:0]}}.
- Half: lane = a[1]. wstrb = 0011 for lane 0, 1100 for lane 1. wdata = {2{wdata[15:0]}}.
- Word: wstrb = 1111, wdata unchanged.
- Alignment is not checked: a[0] is ignored for halves, a[1:0] for words.
- Loads: select the byte or half from rdata by lane.
  - b/h sign-extend; bu/hu zero-extend; w passes through.
  - Unlisted mem_op codes behave as w.
- dmem_req_wstrb = 0 for loads.

Test Plan:
- ALU pass-through: pc=0x80000000, rf_we=1, waddr=5, alu=0x1234 -> next cycle ws_valid=1, ws_bits_rf_wdata=0x1234; back-to-back ALU ops with ws_ready=1 -> one output per cycle.
- lb sign extension: a=0x80000103, rdata=0x80FF0000 -> addr 0x80000100, wstrb=0, rf_wdata=0xFFFFFF80; lbu at the same address -> 0x00000080.
- lh/lhu: a=0x80000102, rdata=0x9ABC1234 -> lh 0xFFFF9ABC, lhu 0x00009ABC; a=...100 -> 0x00001234.
- Store strobes: sb a=0x...01 wdata=0x000000AB -> wstrb=0010, wdata=0xABABABAB; sh a=0x...02 -> wstrb=1100; sw -> 1111. The bundle reaches ws with rf_we=0.
- Backpressure: req_ready held low 3 cycles, then resp delayed 2 cycles, then ws_ready low 2 cycles -> request fields stable, ms_ready=0 throughout, single ws transfer.
- Reset mid-op: assert reset in WAIT, release, then pulse resp_valid -> ws_valid stays 0, state IDLE, ms_ready=1.
